// File: rtl/rr_arbiter_64_pkg.sv
// Shared types, sizes and the round-robin pick function for the 64-requester arbiter.
// Used by the arbiter top, its interface and the index encoder.
package mdclcg_arb_pkg;

  localparam int N_REQ = 64;
  localparam int IDX_W = 6;

  typedef enum logic {IDLE, GRANT} state_t;

  // Rotate so that ptr sits at bit 0, take the lowest set bit, then rotate the result back.
  function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   first;
    logic [IDX_W-1:0]   pos;
    logic               found;
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_REQ-1:0];
    first = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        first = IDX_W'(i);
        found = 1'b1;
      end
    end
    pos = first + ptr;
    rr_pick = found ? (N_REQ'(1) << pos) : '0;
  endfunction

endpackage

// File: rtl/rr_arbiter_64_if.sv
// Request/grant bundle between the requester lanes and the arbiter.
// The lock signal is present only when ARB_LOCK_EN is defined.
interface rr_arbiter_64_if;
  import mdclcg_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             gnt_ready;
`ifdef ARB_LOCK_EN
  logic             lock;

  modport master (output req, gnt_ready, lock, input gnt_onehot, gnt_idx, gnt_valid);
  modport slave  (input req, gnt_ready, lock, output gnt_onehot, gnt_idx, gnt_valid);
`else
  modport master (output req, gnt_ready, input gnt_onehot, gnt_idx, gnt_valid);
  modport slave  (input req, gnt_ready, output gnt_onehot, gnt_idx, gnt_valid);
`endif

endinterface

// File: rtl/rr_arbiter_64_enc.sv
// 64-to-6 one-hot to binary encoder; an all-zero input encodes to index 0.
module rr_arbiter_64_enc
  import mdclcg_arb_pkg::*;
(
  input  logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx
);

  // OR together the indices of all set bits; with a one-hot input that is the bit's index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_arbiter_64.sv
// Round-robin arbiter for 64 requesters with a sticky valid/ready grant towards the datapath.
// Optional ARB_LOCK_EN lets the winner keep the grant across accepts while lock is high.
module rr_arbiter_64
  import mdclcg_arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  rr_arbiter_64_if.slave bus
);

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] after_idx;
  logic [N_REQ-1:0] next_onehot;
  logic [IDX_W-1:0] next_idx;
  logic             accept;
  logic             hold_lock;

`ifdef ARB_LOCK_EN
  assign hold_lock = bus.lock;
`else
  assign hold_lock = 1'b0;
`endif

  assign accept    = bus.gnt_valid & bus.gnt_ready;
  assign after_idx = bus.gnt_idx + IDX_W'(1);

  // On an accept, re-arbitration uses the pointer that is about to be loaded (one past the winner).
  always_comb begin
    next_onehot = '0;
    case (state)
      IDLE:  next_onehot = rr_pick(bus.req, ptr);
      GRANT: begin
        if (!accept || hold_lock) next_onehot = bus.gnt_onehot;
        else                      next_onehot = rr_pick(bus.req, after_idx);
      end
      default: next_onehot = '0;
    endcase
  end

  rr_arbiter_64_enc u_enc (
    .onehot (next_onehot),
    .idx    (next_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.gnt_onehot <= '0;
      bus.gnt_idx    <= '0;
      bus.gnt_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|next_onehot) begin
            state          <= GRANT;
            bus.gnt_onehot <= next_onehot;
            bus.gnt_idx    <= next_idx;
            bus.gnt_valid  <= 1'b1;
          end
        end
        GRANT: begin
          if (accept && !hold_lock) ptr <= after_idx;
          bus.gnt_onehot <= next_onehot;
          bus.gnt_idx    <= next_idx;
          bus.gnt_valid  <= |next_onehot;
          state          <= (|next_onehot) ? GRANT : IDLE;
        end
        default: begin
          state          <= IDLE;
          bus.gnt_onehot <= '0;
          bus.gnt_idx    <= '0;
          bus.gnt_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_64.sv
// Self-checking bench for rr_arbiter_64: directed scenarios plus random traffic against a scan-order model.
// Lock scenarios run only when ARB_LOCK_EN is defined.
module tb_rr_arbiter_64;
  import mdclcg_arb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic lock_v;

  rr_arbiter_64_if bus();

  rr_arbiter_64 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic m_valid;
  int   m_idx;
  int   m_ptr;

  localparam logic [63:0] ALL_ONES = {64{1'b1}};

  // Reference winner: walk ptr, ptr+1, ... around the ring and take the first requester seen.
  function automatic int model_pick(input logic [63:0] r, input int p);
    for (int k = 0; k < 64; k++) begin
      int c;
      c = (p + k) % 64;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic model_update();
    logic lk_eff;
    int   w;
`ifdef ARB_LOCK_EN
    lk_eff = lock_v;
`else
    lk_eff = 1'b0;
`endif
    if (reset) begin
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
    end else if (!m_valid) begin
      w = model_pick(bus.req, m_ptr);
      if (w >= 0) begin
        m_valid = 1'b1;
        m_idx   = w;
      end
    end else if (bus.gnt_ready && !lk_eff) begin
      m_ptr = (m_idx + 1) % 64;
      w = model_pick(bus.req, m_ptr);
      if (w >= 0) begin
        m_idx = w;
      end else begin
        m_valid = 1'b0;
        m_idx   = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [63:0] exp_oh;
    exp_oh = m_valid ? (64'd1 << m_idx) : 64'd0;
    check_output({tag, "/valid"}, {63'd0, bus.gnt_valid}, {63'd0, m_valid});
    check_output({tag, "/idx"}, {58'd0, bus.gnt_idx}, m_valid ? 64'(m_idx) : 64'd0);
    check_output({tag, "/onehot"}, bus.gnt_onehot, exp_oh);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic apply_stimulus(input logic rst, input logic [63:0] r, input logic rdy,
                                input logic lk, input string tag);
    reset         = rst;
    bus.req       = r;
    bus.gnt_ready = rdy;
    lock_v        = lk;
`ifdef ARB_LOCK_EN
    bus.lock      = lk;
`endif
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  initial begin
    logic [63:0] r;
    logic        rst_r, rdy_r, lk_r;

    // Reset with everyone requesting, then the first grant goes to requester 0.
    apply_stimulus(1'b1, ALL_ONES, 1'b0, 1'b0, "t1_reset");
    check_output("t1_reset_valid", {63'd0, bus.gnt_valid}, 64'd0);
    check_output("t1_reset_onehot", bus.gnt_onehot, 64'd0);
    apply_stimulus(1'b0, ALL_ONES, 1'b1, 1'b0, "t1_first");
    check_output("t1_first_idx", {58'd0, bus.gnt_idx}, 64'd0);
    check_output("t1_first_onehot", bus.gnt_onehot, 64'd1);

    // Full ring with ready held high: 1..63 then back to 0, never a bubble.
    for (int i = 1; i <= 64; i++) begin
      apply_stimulus(1'b0, ALL_ONES, 1'b1, 1'b0, "t2_ring");
      check_output("t2_seq_idx", {58'd0, bus.gnt_idx}, 64'(i % 64));
      check_output("t2_seq_valid", {63'd0, bus.gnt_valid}, 64'd1);
    end

    // Sticky grant to 5 while ready is low, then alternate 60 and 5.
    apply_stimulus(1'b1, 64'd0, 1'b0, 1'b0, "t3_reset");
    r = (64'd1 << 5) | (64'd1 << 60);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b0, r, 1'b0, 1'b0, "t3_hold");
      check_output("t3_hold_idx", {58'd0, bus.gnt_idx}, 64'd5);
    end
    apply_stimulus(1'b0, r, 1'b1, 1'b0, "t3_acc1");
    check_output("t3_next_idx", {58'd0, bus.gnt_idx}, 64'd60);
    apply_stimulus(1'b0, r, 1'b1, 1'b0, "t3_acc2");
    check_output("t3_wrap_idx", {58'd0, bus.gnt_idx}, 64'd5);

    // Pointer wrap: grant 61 moves ptr to 62, so 63 wins before 3.
    apply_stimulus(1'b1, 64'd0, 1'b0, 1'b0, "t4_reset");
    apply_stimulus(1'b0, 64'd1 << 61, 1'b0, 1'b0, "t4_g61");
    check_output("t4_g61_idx", {58'd0, bus.gnt_idx}, 64'd61);
    r = (64'd1 << 3) | (64'd1 << 63);
    apply_stimulus(1'b0, r, 1'b1, 1'b0, "t4_g63");
    check_output("t4_g63_idx", {58'd0, bus.gnt_idx}, 64'd63);
    apply_stimulus(1'b0, r, 1'b1, 1'b0, "t4_g3");
    check_output("t4_g3_idx", {58'd0, bus.gnt_idx}, 64'd3);

    // Winner withdraws its request: the grant stays until accepted, then drops to idle.
    apply_stimulus(1'b1, 64'd0, 1'b0, 1'b0, "t5_reset");
    apply_stimulus(1'b0, 64'd1 << 9, 1'b0, 1'b0, "t5_g9");
    apply_stimulus(1'b0, 64'd0, 1'b0, 1'b0, "t5_drop");
    check_output("t5_held_idx", {58'd0, bus.gnt_idx}, 64'd9);
    check_output("t5_held_valid", {63'd0, bus.gnt_valid}, 64'd1);
    apply_stimulus(1'b0, 64'd0, 1'b1, 1'b0, "t5_acc");
    check_output("t5_idle_valid", {63'd0, bus.gnt_valid}, 64'd0);
    check_output("t5_idle_onehot", bus.gnt_onehot, 64'd0);

`ifdef ARB_LOCK_EN
    // Locked accepts keep requester 7; releasing moves on to 8.
    apply_stimulus(1'b1, ALL_ONES, 1'b0, 1'b0, "t6_reset");
    apply_stimulus(1'b0, ALL_ONES, 1'b1, 1'b0, "t6_g0");
    for (int i = 1; i <= 7; i++) apply_stimulus(1'b0, ALL_ONES, 1'b1, 1'b0, "t6_walk");
    check_output("t6_g7_idx", {58'd0, bus.gnt_idx}, 64'd7);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, ALL_ONES, 1'b1, 1'b1, "t6_lock");
      check_output("t6_lock_idx", {58'd0, bus.gnt_idx}, 64'd7);
    end
    apply_stimulus(1'b0, ALL_ONES, 1'b1, 1'b0, "t6_release");
    check_output("t6_release_idx", {58'd0, bus.gnt_idx}, 64'd8);
`endif

    // Reset while a grant is pending clears everything at the next edge.
    apply_stimulus(1'b0, ALL_ONES, 1'b0, 1'b0, "t7_pending");
    apply_stimulus(1'b1, ALL_ONES, 1'b1, 1'b0, "t7_reset");
    check_output("t7_reset_valid", {63'd0, bus.gnt_valid}, 64'd0);
    check_output("t7_reset_onehot", bus.gnt_onehot, 64'd0);

    // Random traffic of varying density, with occasional resets.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 64'd0;
        1:       r = 64'd1 << $urandom_range(0, 63);
        2:       r = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: r = {$urandom, $urandom};
      endcase
      rst_r = ($urandom_range(0, 39) == 0);
      rdy_r = 1'($urandom_range(0, 1));
      lk_r  = 1'($urandom_range(0, 1));
      apply_stimulus(rst_r, r, rdy_r, lk_r, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
